// File: rtl/operand_fetch_if.sv
// Bundle of decode, register-file, execute and writeback signals seen by
// operand_fetch.
//   master : operand_fetch side (drives in_ready, rf_reg*, out_*, rf_*write*)
//   slave  : environment side (decode, register file, execute, writeback)
interface operand_fetch_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_wr_en;

    logic [ADDR_W-1:0] rf_reg1;
    logic [ADDR_W-1:0] rf_reg2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op1;
    logic [DATA_W-1:0] out_op2;
    logic [ADDR_W-1:0] out_rd;
    logic              out_wr_en;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              rf_do_write;
    logic [ADDR_W-1:0] rf_reg_write;
    logic [DATA_W-1:0] rf_write_data;

    modport master (
        input  in_valid, in_rs1, in_rs2, in_rd, in_wr_en,
        output in_ready,
        output rf_reg1, rf_reg2,
        input  rf_data1, rf_data2,
        output out_valid, out_op1, out_op2, out_rd, out_wr_en,
        input  out_ready,
        input  wb_valid, wb_rd, wb_data,
        output rf_do_write, rf_reg_write, rf_write_data
    );

    modport slave (
        output in_valid, in_rs1, in_rs2, in_rd, in_wr_en,
        input  in_ready,
        input  rf_reg1, rf_reg2,
        output rf_data1, rf_data2,
        input  out_valid, out_op1, out_op2, out_rd, out_wr_en,
        output out_ready,
        output wb_valid, wb_rd, wb_data,
        input  rf_do_write, rf_reg_write, rf_write_data
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: initiator side of a small register file.
// Accepts decoded instructions, drives the file's read addresses, captures
// the negedge-registered read data and hands both operands to execute over
// valid/ready. Owns the file's write port for writeback and keeps a
// per-register pending scoreboard that stalls reads of in-flight results.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : operand_fetch_if.master (decode / rf / execute / writeback)
//
// state | meaning
// IDLE  | ready for an instruction (in_ready=1)
// STALL | a source register has an outstanding write
// READ  | file samples the read addresses at this cycle's negedge
// HOLD  | operands valid, waiting for out_ready
module operand_fetch #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, STALL, READ, HOLD} state_t;

    state_t            r_state;
    logic [NREG-1:0]   r_pending;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] r_rd;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_out_valid;

    logic              w_out_fire;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic [NREG-1:0]   w_pending_clr;

    always_comb begin
        w_out_fire = (r_state == HOLD) && bus.out_ready;
        w_set      = '0;
        w_clr      = '0;
        if (w_out_fire && r_wr_en)
            w_set[r_rd] = 1'b1;
        if (bus.wb_valid)
            w_clr[bus.wb_rd] = 1'b1;
    end

    // Scoreboard with this cycle's writeback already removed. STALL looks at
    // this so a source freed in cycle N is read in cycle N+1, after the
    // file's write at the same edge.
    assign w_pending_clr = r_pending & ~w_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_wr_en     <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Set is applied after clear so a simultaneous set wins.
            r_pending <= w_pending_clr | w_set;

            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_rs1   <= bus.in_rs1;
                        r_rs2   <= bus.in_rs2;
                        r_rd    <= bus.in_rd;
                        r_wr_en <= bus.in_wr_en;
                        if (r_pending[bus.in_rs1] || r_pending[bus.in_rs2])
                            r_state <= STALL;
                        else
                            r_state <= READ;
                    end
                end
                STALL: begin
                    if (!w_pending_clr[r_rs1] && !w_pending_clr[r_rs2])
                        r_state <= READ;
                end
                READ: begin
                    r_op1       <= bus.rf_data1;
                    r_op2       <= bus.rf_data2;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.rf_reg1   = r_rs1;
    assign bus.rf_reg2   = r_rs2;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op1   = r_op1;
    assign bus.out_op2   = r_op2;
    assign bus.out_rd    = r_rd;
    assign bus.out_wr_en = r_wr_en;

    assign bus.rf_do_write   = bus.wb_valid;
    assign bus.rf_reg_write  = bus.wb_valid ? bus.wb_rd   : '0;
    assign bus.rf_write_data = bus.wb_valid ? bus.wb_data : '0;
endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file: writes at posedge, read data registered at negedge.
    logic [7:0] rf_mem [4];
    always @(posedge clk) begin
        if (bus.rf_do_write)
            rf_mem[bus.rf_reg_write] <= bus.rf_write_data;
    end
    always @(negedge clk) begin
        bus.rf_data1 <= rf_mem[bus.rf_reg1];
        bus.rf_data2 <= rf_mem[bus.rf_reg2];
    end

    // Reference model: architectural register values and outstanding writes.
    logic [7:0] m_regs [4];
    logic [3:0] m_pend;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       v;
        logic [1:0] rd;
        logic [7:0] d;
        logic       e_we;
        logic [1:0] e_rd;
        logic [7:0] e_d;
    } wvec_t;

    wvec_t wtab [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] rd, input logic [7:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
        tick();
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        m_regs[rd]   = d;
        m_pend[rd]   = 1'b0;
    endtask

    // Full instruction: accept, optional stall resolved by writebacks of the
    // pending sources, READ, HOLD for 'hold' cycles, then handshake with an
    // optional concurrent writeback.
    task automatic do_issue(input logic [1:0] rs1, input logic [1:0] rs2,
                            input logic [1:0] rd, input logic wr,
                            input int gap, input logic [7:0] sdata, input int hold,
                            input logic hs_wb, input logic [1:0] hs_rd,
                            input logic [7:0] hs_data);
        logic       stalled;
        logic [1:0] r;
        logic [7:0] e1;
        logic [7:0] e2;
        stalled = m_pend[rs1] | m_pend[rs2];
        chk("in_ready_idle", {31'd0, bus.in_ready}, 1);
        bus.in_valid = 1'b1;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
        bus.in_wr_en = wr;
        tick();
        bus.in_valid = 1'b0;
        chk("rf_reg1", {30'd0, bus.rf_reg1}, {30'd0, rs1});
        chk("rf_reg2", {30'd0, bus.rf_reg2}, {30'd0, rs2});
        if (stalled) begin
            for (int i = 0; i < gap; i++) begin
                chk("stall_in_ready", {31'd0, bus.in_ready}, 0);
                chk("stall_out_valid", {31'd0, bus.out_valid}, 0);
                tick();
            end
            while (m_pend[rs1] || m_pend[rs2]) begin
                chk("stall_in_ready", {31'd0, bus.in_ready}, 0);
                r = m_pend[rs1] ? rs1 : rs2;
                wb_write(r, (r == rs1) ? sdata : ~sdata);
            end
        end
        chk("read_out_valid", {31'd0, bus.out_valid}, 0);
        chk("read_in_ready", {31'd0, bus.in_ready}, 0);
        tick();
        e1 = m_regs[rs1];
        e2 = m_regs[rs2];
        chk("out_valid", {31'd0, bus.out_valid}, 1);
        chk("out_op1", {24'd0, bus.out_op1}, {24'd0, e1});
        chk("out_op2", {24'd0, bus.out_op2}, {24'd0, e2});
        chk("out_rd", {30'd0, bus.out_rd}, {30'd0, rd});
        chk("out_wr_en", {31'd0, bus.out_wr_en}, {31'd0, wr});
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            tick();
            chk("hold_valid", {31'd0, bus.out_valid}, 1);
            chk("hold_op1", {24'd0, bus.out_op1}, {24'd0, e1});
            chk("hold_op2", {24'd0, bus.out_op2}, {24'd0, e2});
            chk("hold_rd", {30'd0, bus.out_rd}, {30'd0, rd});
            chk("hold_in_ready", {31'd0, bus.in_ready}, 0);
            chk("hold_pending", {28'd0, dut.r_pending}, {28'd0, m_pend});
        end
        bus.out_ready = 1'b1;
        if (hs_wb) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = hs_rd;
            bus.wb_data  = hs_data;
        end
        tick();
        bus.out_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        if (hs_wb) begin
            m_regs[hs_rd] = hs_data;
            m_pend[hs_rd] = 1'b0;
        end
        if (wr)
            m_pend[rd] = 1'b1;
        chk("post_valid", {31'd0, bus.out_valid}, 0);
        chk("post_in_ready", {31'd0, bus.in_ready}, 1);
        chk("post_pending", {28'd0, dut.r_pending}, {28'd0, m_pend});
    endtask

    initial begin
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        logic [1:0] h;
        logic       w;
        logic       hw;

        wtab[0] = '{1'b1, 2'd1, 8'h12, 1'b1, 2'd1, 8'h12};
        wtab[1] = '{1'b1, 2'd2, 8'h34, 1'b1, 2'd2, 8'h34};
        wtab[2] = '{1'b0, 2'd3, 8'hFF, 1'b0, 2'd0, 8'h00};
        wtab[3] = '{1'b1, 2'd0, 8'hA5, 1'b1, 2'd0, 8'hA5};
        wtab[4] = '{1'b1, 2'd3, 8'hC3, 1'b1, 2'd3, 8'hC3};
        wtab[5] = '{1'b0, 2'd2, 8'h77, 1'b0, 2'd0, 8'h00};

        bus.in_valid  = 1'b0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_rd     = '0;
        bus.in_wr_en  = 1'b0;
        bus.out_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        m_pend        = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_rf_reg1", {30'd0, bus.rf_reg1}, 0);
        chk("rst_rf_reg2", {30'd0, bus.rf_reg2}, 0);
        chk("rst_op1", {24'd0, bus.out_op1}, 0);
        chk("rst_op2", {24'd0, bus.out_op2}, 0);
        chk("rst_out_rd", {30'd0, bus.out_rd}, 0);
        chk("rst_out_wr_en", {31'd0, bus.out_wr_en}, 0);
        chk("rst_pending", {28'd0, dut.r_pending}, 0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);

        // Write-port pass-through table; also preloads the file
        for (int i = 0; i < 6; i++) begin
            bus.wb_valid = wtab[i].v;
            bus.wb_rd    = wtab[i].rd;
            bus.wb_data  = wtab[i].d;
            #1;
            chk("wp_do_write", {31'd0, bus.rf_do_write}, {31'd0, wtab[i].e_we});
            chk("wp_reg", {30'd0, bus.rf_reg_write}, {30'd0, wtab[i].e_rd});
            chk("wp_data", {24'd0, bus.rf_write_data}, {24'd0, wtab[i].e_d});
            tick();
            if (wtab[i].v) m_regs[wtab[i].rd] = wtab[i].d;
            bus.wb_valid = 1'b0;
            bus.wb_rd    = '0;
            bus.wb_data  = '0;
        end
        chk("wp_pending", {28'd0, dut.r_pending}, 0);

        // 1: unstalled issue, R1/R2 operands, pending[3] after handshake
        do_issue(2'd1, 2'd2, 2'd3, 1'b1, 0, 8'h00, 0, 1'b0, 2'd0, 8'h00);
        chk("t1_op_consts", {16'd0, m_regs[1], m_regs[2]}, 32'h1234);
        chk("t1_pend3", {31'd0, dut.r_pending[3]}, 1);

        // 2: stall on R3 for 4 cycles, released by wb 0x5A
        do_issue(2'd3, 2'd0, 2'd1, 1'b0, 4, 8'h5A, 0, 1'b0, 2'd0, 8'h00);
        chk("t2_r3", {24'd0, m_regs[3]}, 32'h5A);

        // 3: HOLD with out_ready low for 5 cycles
        do_issue(2'd1, 2'd2, 2'd0, 1'b0, 0, 8'h00, 5, 1'b0, 2'd0, 8'h00);

        // 4: set and clear of R2 in the same cycle; set wins, next read stalls
        do_issue(2'd0, 2'd1, 2'd2, 1'b1, 0, 8'h00, 0, 1'b0, 2'd0, 8'h00);
        do_issue(2'd0, 2'd1, 2'd2, 1'b1, 0, 8'h00, 1, 1'b1, 2'd2, 8'h77);
        chk("t4_set_wins", {31'd0, dut.r_pending[2]}, 1);
        do_issue(2'd2, 2'd0, 2'd0, 1'b0, 1, 8'h3C, 0, 1'b0, 2'd0, 8'h00);

        // 5: reset during STALL with pending=1010
        do_issue(2'd0, 2'd0, 2'd1, 1'b1, 0, 8'h00, 0, 1'b0, 2'd0, 8'h00);
        do_issue(2'd0, 2'd2, 2'd3, 1'b1, 0, 8'h00, 0, 1'b0, 2'd0, 8'h00);
        chk("t5_pending_1010", {28'd0, dut.r_pending}, 32'hA);
        bus.in_valid = 1'b1;
        bus.in_rs1   = 2'd1;
        bus.in_rs2   = 2'd3;
        bus.in_rd    = 2'd0;
        bus.in_wr_en = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t5_stall_in_ready", {31'd0, bus.in_ready}, 0);
        chk("t5_stall_reg1", {30'd0, bus.rf_reg1}, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, bus.out_valid}, 0);
        chk("t5_rst_reg1", {30'd0, bus.rf_reg1}, 0);
        chk("t5_rst_reg2", {30'd0, bus.rf_reg2}, 0);
        chk("t5_rst_pending", {28'd0, dut.r_pending}, 0);
        tick();
        reset  = 1'b0;
        m_pend = '0;
        tick();
        do_issue(2'd1, 2'd3, 2'd2, 1'b0, 0, 8'h00, 0, 1'b0, 2'd0, 8'h00);

        // 6: R0/R0 with no write
        do_issue(2'd0, 2'd0, 2'd0, 1'b0, 0, 8'h00, 0, 1'b0, 2'd0, 8'h00);
        chk("t6_no_pend", {28'd0, dut.r_pending}, 0);

        // Randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                c = 2'($urandom_range(0, 3));
                wb_write(c, 8'($urandom));
                chk("rnd_idle_pend", {28'd0, dut.r_pending}, {28'd0, m_pend});
            end
            a  = 2'($urandom_range(0, 3));
            b  = 2'($urandom_range(0, 3));
            c  = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            hw = 1'b0;
            h  = 2'd0;
            if (m_pend != 4'd0 && $urandom_range(0, 1) == 1) begin
                hw = 1'b1;
                h  = 2'($urandom_range(0, 3));
                while (!m_pend[h]) h = h + 2'd1;
            end
            do_issue(a, b, c, w, $urandom_range(0, 3), 8'($urandom),
                     $urandom_range(0, 2), hw, h, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
